// File: rtl/rv_pkg.sv
// Shared fetch-side definitions.
//   pcsrc_t           : execute-stage PC source select
//   RESET_PC_DEFAULT  : default reset vector for the fetch PC
package rv_pkg;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_TGT  = 2'b01,
        PC_JALR = 2'b10,
        PC_RSVD = 2'b11
    } pcsrc_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO that buffers prefetched {instr, pc, pc+4} words.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   clr_i              discard all entries at the next edge (wins over enq/deq)
//   enq_i, data_i      push data_i (caller guarantees !full_o || deq_i)
//   deq_i              pop head (caller guarantees !empty_o)
//   data_o             head entry, valid while !empty_o
//   full_o, empty_o    occupancy flags
//   count_o            number of occupied entries
module fetch_fifo
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             enq_i,
    input  logic             deq_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    // Pointers wrap naturally because DEPTH is a power of two; the count is
    // kept separately so full and empty are unambiguous.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (deq_i) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(enq_i) - CW'(deq_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_i && !clr_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage with a prefetch queue between instruction memory and decode.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   PCSrcE_i                 00/11 sequential, 01 PCTargetE_i, 10 ALUResultE_i
//   PCTargetE_i              branch/jal target from execute
//   ALUResultE_i             jalr target from execute
//   StallF_i                 hold PC and suppress enqueue (dequeue continues)
//   ImemAddr_o / ImemRD_i    instruction-memory address and combinational read data
//   ValidD_o / ReadyD_i      head handshake to decode
//   InstrD_o, PCD_o,
//   PCPlus4D_o               head entry fields
//   CountF_o                 queue occupancy
module fetch_queue_unit
    import rv_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
    localparam int              CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       PCSrcE_i,
    input  logic [WIDTH-1:0] PCTargetE_i,
    input  logic [WIDTH-1:0] ALUResultE_i,
    input  logic             StallF_i,
    output logic [WIDTH-1:0] ImemAddr_o,
    input  logic [WIDTH-1:0] ImemRD_i,
    output logic             ValidD_o,
    input  logic             ReadyD_i,
    output logic [WIDTH-1:0] InstrD_o,
    output logic [WIDTH-1:0] PCD_o,
    output logic [WIDTH-1:0] PCPlus4D_o,
    output logic [CW-1:0]    CountF_o
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));

    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [WIDTH-1:0]   pc_plus4;
    logic [WIDTH-1:0]   target;
    logic               redirect;
    logic               enq, deq;
    logic               full, empty;
    logic [3*WIDTH-1:0] head;
    pcsrc_t             pcsrc;

    assign pcsrc    = pcsrc_t'(PCSrcE_i);
    assign pc_plus4 = pc_q + WIDTH'(4);

    // Both redirect targets are word-aligned; masking bits [1:0] also covers
    // the jalr bit0 clear.
    always_comb begin
        redirect = 1'b0;
        target   = '0;
        case (pcsrc)
            PC_TGT: begin
                redirect = 1'b1;
                target   = PCTargetE_i & ALIGN_MASK;
            end
            PC_JALR: begin
                redirect = 1'b1;
                target   = ALUResultE_i & ALIGN_MASK;
            end
            default: ;
        endcase
    end

    // The head is hidden during a redirect so decode can never take a
    // wrong-path word in the same cycle the flush is requested.
    assign ValidD_o = !rst && !redirect && !empty;
    assign deq      = ValidD_o && ReadyD_i;
    assign enq      = !rst && !redirect && !StallF_i && (!full || deq);

    always_comb begin
        pc_d = pc_q;
        if (rst)           pc_d = RESET_PC;
        else if (redirect) pc_d = target;
        else if (enq)      pc_d = pc_plus4;
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    fetch_fifo #(
        .WIDTH (3 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (rst || redirect),
        .enq_i   (enq),
        .deq_i   (deq),
        .data_i  ({ImemRD_i, pc_q, pc_plus4}),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (CountF_o)
    );

    assign {InstrD_o, PCD_o, PCPlus4D_o} = head;
    assign ImemAddr_o = rst ? RESET_PC : pc_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: a reference fetch model pushes expected entries
// into a scoreboard queue on every modelled fetch; entries are popped and
// compared when decode accepts the head. Directed scenarios add fixed checks.
module tb_fetch_queue_unit;
    import rv_pkg::*;

    localparam int          WIDTH  = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  PCSrcE_i;
    logic [31:0] PCTargetE_i, ALUResultE_i;
    logic        StallF_i;
    logic [31:0] ImemAddr_o, ImemRD_i;
    logic        ValidD_o, ReadyD_i;
    logic [31:0] InstrD_o, PCD_o, PCPlus4D_o;
    logic [2:0]  CountF_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ent_t;

    ent_t        sb[$];
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    // Instruction memory: word i holds value i.
    assign ImemRD_i = {2'b00, ImemAddr_o[31:2]};

    fetch_queue_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .PCSrcE_i     (PCSrcE_i),
        .PCTargetE_i  (PCTargetE_i),
        .ALUResultE_i (ALUResultE_i),
        .StallF_i     (StallF_i),
        .ImemAddr_o   (ImemAddr_o),
        .ImemRD_i     (ImemRD_i),
        .ValidD_o     (ValidD_o),
        .ReadyD_i     (ReadyD_i),
        .InstrD_o     (InstrD_o),
        .PCD_o        (PCD_o),
        .PCPlus4D_o   (PCPlus4D_o),
        .CountF_o     (CountF_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_redir(input logic [1:0] src);
        return (src == 2'b01) || (src == 2'b10);
    endfunction

    task automatic sb_check();
        bit exp_valid;
        if (rst) begin
            check_eq("rst_valid", 32'(ValidD_o), 32'd0);
            check_eq("rst_addr", ImemAddr_o, RST_PC);
        end else begin
            exp_valid = (sb.size() > 0) && !is_redir(PCSrcE_i);
            check_eq("valid", 32'(ValidD_o), 32'(exp_valid));
            check_eq("addr", ImemAddr_o, m_pc);
            check_eq("count", 32'(CountF_o), 32'(sb.size()));
            if (exp_valid && ReadyD_i) begin
                check_eq("head_pc", PCD_o, sb[0].pc);
                check_eq("head_instr", InstrD_o, sb[0].instr);
                check_eq("head_pc4", PCPlus4D_o, sb[0].pc4);
            end
        end
    endtask

    task automatic model_update();
        bit deq, enq;
        if (rst) begin
            m_pc = RST_PC;
            sb.delete();
        end else if (PCSrcE_i == 2'b01) begin
            m_pc = PCTargetE_i & 32'hFFFF_FFFC;
            sb.delete();
        end else if (PCSrcE_i == 2'b10) begin
            m_pc = ALUResultE_i & 32'hFFFF_FFFC;
            sb.delete();
        end else begin
            deq = (sb.size() > 0) && ReadyD_i;
            enq = !StallF_i && ((sb.size() < DEPTH) || deq);
            if (deq) void'(sb.pop_front());
            if (enq) begin
                sb.push_back('{instr: m_pc >> 2, pc: m_pc, pc4: m_pc + 32'd4});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] src, input logic [31:0] tgt,
                         input logic [31:0] alu, input logic stall, input logic rdy);
        rst          = r;
        PCSrcE_i     = src;
        PCTargetE_i  = tgt;
        ALUResultE_i = alu;
        StallF_i     = stall;
        ReadyD_i     = rdy;
        @(negedge clk);
        sb_check();
    endtask

    task automatic fin();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cyc(input logic r, input logic [1:0] src, input logic [31:0] tgt,
                       input logic [31:0] alu, input logic stall, input logic rdy);
        drive(r, src, tgt, alu, stall, rdy);
        fin();
    endtask

    task automatic do_reset();
        cyc(1, 2'b00, 0, 0, 0, 1);
        cyc(1, 2'b00, 0, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b1; PCSrcE_i = 2'b00; PCTargetE_i = '0; ALUResultE_i = '0;
        StallF_i = 1'b0; ReadyD_i = 1'b0;
        @(posedge clk); #1;

        // 1: streaming after reset
        do_reset();
        drive(0, 2'b00, 0, 0, 0, 1);
        check_eq("t1_valid_first", 32'(ValidD_o), 32'd0);
        fin();
        for (int i = 0; i < 5; i++) begin
            drive(0, 2'b00, 0, 0, 0, 1);
            check_eq("t1_valid", 32'(ValidD_o), 32'd1);
            check_eq("t1_pc", PCD_o, 32'(i * 4));
            check_eq("t1_instr", InstrD_o, 32'(i));
            fin();
        end

        // 2: fill to full, then drain in order
        do_reset();
        for (int i = 0; i < 6; i++) cyc(0, 2'b00, 0, 0, 0, 0);
        drive(0, 2'b00, 0, 0, 0, 0);
        check_eq("t2_count_full", 32'(CountF_o), 32'd4);
        check_eq("t2_addr_hold", ImemAddr_o, 32'h10);
        fin();
        for (int i = 0; i < 5; i++) begin
            drive(0, 2'b00, 0, 0, 0, 1);
            check_eq("t2_drain_valid", 32'(ValidD_o), 32'd1);
            check_eq("t2_drain_pc", PCD_o, 32'(i * 4));
            fin();
        end

        // 3: branch flush with 3 entries queued
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 2'b00, 0, 0, 0, 0);
        drive(0, 2'b01, 32'h100, 0, 0, 1);
        check_eq("t3_valid_redir", 32'(ValidD_o), 32'd0);
        check_eq("t3_count_pre", 32'(CountF_o), 32'd3);
        fin();
        drive(0, 2'b00, 0, 0, 0, 1);
        check_eq("t3_count_flush", 32'(CountF_o), 32'd0);
        check_eq("t3_addr_tgt", ImemAddr_o, 32'h100);
        fin();
        drive(0, 2'b00, 0, 0, 0, 1);
        check_eq("t3_valid_tgt", 32'(ValidD_o), 32'd1);
        check_eq("t3_pc_tgt", PCD_o, 32'h100);
        fin();

        // 4: jalr target alignment
        drive(0, 2'b10, 0, 32'h203, 0, 1);
        check_eq("t4_valid_redir", 32'(ValidD_o), 32'd0);
        fin();
        drive(0, 2'b00, 0, 0, 0, 1);
        check_eq("t4_addr", ImemAddr_o, 32'h200);
        fin();
        drive(0, 2'b00, 0, 0, 0, 1);
        check_eq("t4_pc", PCD_o, 32'h200);
        check_eq("t4_pc4", PCPlus4D_o, 32'h204);
        fin();

        // 5: stall drains the queue while PC holds
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 2'b00, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 2'b00, 0, 0, 1, 1);
            check_eq("t5_addr_stall", ImemAddr_o, 32'hC);
            fin();
        end
        drive(0, 2'b00, 0, 0, 0, 1);
        check_eq("t5_count_drained", 32'(CountF_o), 32'd0);
        check_eq("t5_addr_resume", ImemAddr_o, 32'hC);
        fin();
        drive(0, 2'b00, 0, 0, 0, 1);
        check_eq("t5_pc_resume", PCD_o, 32'hC);
        fin();

        // 6: reset beats a pending redirect on a full queue
        do_reset();
        for (int i = 0; i < 6; i++) cyc(0, 2'b00, 0, 0, 0, 0);
        drive(1, 2'b01, 32'h300, 0, 0, 0);
        check_eq("t6_valid_rst", 32'(ValidD_o), 32'd0);
        check_eq("t6_addr_rst", ImemAddr_o, RST_PC);
        fin();
        drive(0, 2'b00, 0, 0, 0, 0);
        check_eq("t6_count", 32'(CountF_o), 32'd0);
        check_eq("t6_valid", 32'(ValidD_o), 32'd0);
        check_eq("t6_addr", ImemAddr_o, RST_PC);
        fin();
        drive(0, 2'b00, 0, 0, 0, 1);
        check_eq("t6_first_pc", PCD_o, RST_PC);
        fin();

        // 7: PC+4 wraps at the top of the address space
        drive(0, 2'b01, 32'hFFFF_FFFF, 0, 0, 1);
        fin();
        drive(0, 2'b00, 0, 0, 0, 1);
        check_eq("t7_addr", ImemAddr_o, 32'hFFFF_FFFC);
        fin();
        drive(0, 2'b00, 0, 0, 0, 1);
        check_eq("t7_pc", PCD_o, 32'hFFFF_FFFC);
        check_eq("t7_pc4_wrap", PCPlus4D_o, 32'h0);
        fin();
        drive(0, 2'b00, 0, 0, 0, 1);
        check_eq("t7_pc_wrapped", PCD_o, 32'h0);
        fin();

        // Random traffic against the scoreboard model
        for (int i = 0; i < 400; i++) begin
            logic [1:0] src;
            int         sel;
            sel = int'($urandom_range(0, 15));
            case (sel)
                0:       src = 2'b01;
                1:       src = 2'b10;
                2:       src = 2'b11;
                default: src = 2'b00;
            endcase
            cyc(($urandom_range(0, 49) == 0), src, $urandom(), $urandom(),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
